// File: rtl/rf_fifo_ctrl.sv
// FIFO controller in front of an 8x32 register file: pointers, occupancy, flags and handshake.
// Optional almost_full/almost_empty ports are enabled by defining RF_FIFO_ALMOST_FLAGS_EN.
module rf_fifo_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rf_rData,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wAddr,
   output logic [ADDR_W-1:0] rf_rAddr,
   output logic [DATA_W-1:0] d_out,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   data_count,
`ifdef RF_FIFO_ALMOST_FLAGS_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output logic              wr_ack,
   output logic              wr_err,
   output logic              rd_ack,
   output logic              rd_err
);

   // state      | meaning
   // S_INIT     | after reset, no request seen yet
   // S_NO_OP    | idle, or push and pop together (ignored)
   // S_WRITE    | push accepted on the last edge
   // S_WR_ERROR | push rejected, FIFO was full
   // S_READ     | pop accepted, d_out carries the popped word
   // S_RD_ERROR | pop rejected, FIFO was empty
   typedef enum logic [2:0] {
      S_INIT, S_NO_OP, S_WRITE, S_WR_ERROR, S_READ, S_RD_ERROR
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   head_q, head_d;
   logic [ADDR_W-1:0]   tail_q, tail_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [DATA_W-1:0]   d_out_q, d_out_d;
   logic                push_only, pop_only;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_INIT;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         d_out_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         d_out_q <= d_out_d;
      end
   end

   assign push_only = wr_en & ~rd_en;
   assign pop_only  = rd_en & ~wr_en;

   always_comb begin
      state_d = S_NO_OP;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      d_out_d = d_out_q;
      if (push_only) begin
         if (full) begin
            state_d = S_WR_ERROR;
         end else begin
            state_d = S_WRITE;
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
         end
      end else if (pop_only) begin
         if (empty) begin
            state_d = S_RD_ERROR;
         end else begin
            state_d = S_READ;
            d_out_d = rf_rData;
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
         end
      end
   end

   always_comb begin
      wr_ack = (state_q == S_WRITE);
      wr_err = (state_q == S_WR_ERROR);
      rd_ack = (state_q == S_READ);
      rd_err = (state_q == S_RD_ERROR);
   end

   // Flags come from the count so a full FIFO is never mistaken for an empty one.
   assign full       = (count_q == DEPTH_C);
   assign empty      = (count_q == '0);
   assign data_count = count_q;
   assign rf_wAddr   = tail_q;
   assign rf_rAddr   = head_q;
   assign d_out      = d_out_q;
   // Gated by reset_n so a push presented during reset never touches storage.
   assign rf_we      = push_only & ~full & reset_n;

`ifdef RF_FIFO_ALMOST_FLAGS_EN
   assign almost_full  = (count_q >= (DEPTH_C - ONE_C));
   assign almost_empty = (count_q <= ONE_C);
`endif

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Scoreboard bench for rf_fifo_ctrl with a behavioural queue model and a register-file model.
module tb_rf_fifo_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_en, rd_en;
   logic [31:0] wdata;
   logic [31:0] rf_rData;
   logic        rf_we;
   logic [2:0]  rf_wAddr, rf_rAddr;
   logic [31:0] d_out;
   logic        full, empty;
   logic [3:0]  data_count;
   logic        wr_ack, wr_err, rd_ack, rd_err;
`ifdef RF_FIFO_ALMOST_FLAGS_EN
   logic        almost_full, almost_empty;
`endif

   always #5 clk = ~clk;

   rf_fifo_ctrl #(.ADDR_W(3), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
      .rf_rData(rf_rData), .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_rAddr(rf_rAddr),
      .d_out(d_out), .full(full), .empty(empty), .data_count(data_count),
`ifdef RF_FIFO_ALMOST_FLAGS_EN
      .almost_full(almost_full), .almost_empty(almost_empty),
`endif
      .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
   );

   // Register file: synchronous write, combinational read.
   logic [31:0] mem [8];
   initial for (int i = 0; i < 8; i++) mem[i] = 32'h0;
   always @(posedge clk) if (rf_we) mem[rf_wAddr] <= wdata;
   assign rf_rData = mem[rf_rAddr];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, pointers as push/pop counts mod 8.
   logic [31:0] mq [$];
   int          head_m = 0, tail_m = 0;
   logic [31:0] dout_m = 32'h0;

   typedef struct {
      logic [3:0]  hs;     // {wr_ack, wr_err, rd_ack, rd_err}
      logic [31:0] dout;
      int          cnt;
   } exp_t;
   exp_t sb [$];
   bit   mon_on = 1'b0;

   task automatic cycle(input logic we, input logic re, input logic [31:0] wd);
      exp_t e;
      @(negedge clk);
      reset_n = 1'b1; wr_en = we; rd_en = re; wdata = wd;
      #1;
      chk("data_count", data_count, mq.size());
      chk("full", full, mq.size() == 8);
      chk("empty", empty, mq.size() == 0);
      chk("rf_wAddr", rf_wAddr, tail_m);
      chk("rf_rAddr", rf_rAddr, head_m);
      chk("d_out_hold", d_out, dout_m);
      chk("rf_we", rf_we, we && !re && mq.size() < 8);
`ifdef RF_FIFO_ALMOST_FLAGS_EN
      chk("almost_full", almost_full, mq.size() >= 7);
      chk("almost_empty", almost_empty, mq.size() <= 1);
`endif
      if (we && !re) begin
         if (mq.size() < 8) begin
            mq.push_back(wd);
            tail_m = (tail_m + 1) % 8;
            e.hs = 4'b1000;
         end else e.hs = 4'b0100;
         e.dout = dout_m; e.cnt = mq.size();
         sb.push_back(e);
      end else if (re && !we) begin
         if (mq.size() > 0) begin
            dout_m = mq.pop_front();
            head_m = (head_m + 1) % 8;
            e.hs = 4'b0010;
         end else e.hs = 4'b0001;
         e.dout = dout_m; e.cnt = mq.size();
         sb.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0; wdata = $urandom;
      #1;
      chk("rf_we_in_reset", rf_we, 1'b0);
      mq.delete(); head_m = 0; tail_m = 0; dout_m = 32'h0;
   endtask

   // Monitor: each negedge shows the handshake of the previous edge's request, if any.
   exp_t       me;
   logic [3:0] hs;
   always @(negedge clk) begin
      if (mon_on) begin
         hs = {wr_ack, wr_err, rd_ack, rd_err};
         if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("handshake", hs, me.hs);
            chk("d_out_resp", d_out, me.dout);
            chk("count_resp", data_count, me.cnt);
         end else begin
            chk("idle_handshake", hs, 4'b0000);
         end
      end
   end

   initial begin
      reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mon_on = 1'b1;
      cycle(0, 0, 0);
      cycle(0, 0, 0);

      // fill, overflow, drain, underflow
      for (int k = 1; k <= 8; k++) cycle(1, 0, 32'h11111111 * k);
      cycle(1, 0, 32'hDEADBEEF);
      for (int k = 0; k < 9; k++) cycle(0, 1, 0);

      // wrap-around
      for (int k = 0; k < 5; k++) cycle(1, 0, $urandom);
      for (int k = 0; k < 5; k++) cycle(0, 1, 0);
      for (int k = 0; k < 6; k++) cycle(1, 0, $urandom);
      cycle(0, 0, 0);
      for (int k = 0; k < 6; k++) cycle(0, 1, 0);

      // simultaneous push and pop at count 3
      for (int k = 0; k < 3; k++) cycle(1, 0, $urandom);
      cycle(1, 1, 32'hCAFEF00D);
      cycle(1, 1, 32'h0BADF00D);
      cycle(0, 0, 0);

      // reset mid-stream at count 4, then pop from empty
      cycle(1, 0, $urandom);
      do_reset();
      cycle(0, 1, 0);
      cycle(0, 0, 0);

      // random traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) < 2) do_reset();
         else cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end

      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_fifo_ctrl.md
Name: rf_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the 8x32 register file.
- Turns push/pop requests into register-file write and read controls: rf_we, rf_wAddr, rf_rAddr.
- Captures the register file's combinational read data into a registered output.
- The register file is the storage; this block owns the pointers, occupancy count, status flags and handshake.

Parameters:
- ADDR_W, 3, pointer width; depth = 2**ADDR_W = 8 entries.
- DATA_W, 32, data width; matches the register-file word.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- wr_en  input  1  push request; the data is already on the register file's wData bus from the upstream source.
- rd_en  input  1  pop request.
- rf_rData  input  DATA_W  register-file read data (combinational from rf_rAddr).
- rf_we  output  1  register-file write enable.
- rf_wAddr  output  ADDR_W  register-file write address (tail pointer).
- rf_rAddr  output  ADDR_W  register-file read address (head pointer).
- d_out  output  DATA_W  registered popped word.
- full  output  1  count == 8.
- empty  output  1  count == 0.
- data_count  output  ADDR_W+1  occupancy, 0..8.
- wr_ack, wr_err, rd_ack, rd_err  output  1 each  one-cycle handshake pulses.

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset (reset_n=0 at an edge), no matter what is in progress:
  - head=0, tail=0, count=0, d_out=0.
  - state=INIT; all acks/errs low.
  - Register-file contents are not cleared; they are don't-care once count is 0.
- Combinational outputs:
  - full = (count==8); empty = (count==0); data_count = count.
  - rf_wAddr = tail; rf_rAddr = head.
  - rf_we = wr_en & ~rd_en & ~full & reset_n. The register file writes on the same edge the push is accepted; latency 0.
- State register, updated every edge from the inputs sampled at that edge. Codes: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR.
  - wr_en=1, rd_en=0, ~full: → WRITE; tail=tail+1 mod 8; count+1.
  - wr_en=1, rd_en=0, full: → WR_ERROR; pointers, count and storage unchanged.
  - rd_en=1, wr_en=0, ~empty: → READ; d_out<=rf_rData (entry at head); head=head+1 mod 8; count-1.
  - rd_en=1, wr_en=0, empty: → RD_ERROR; d_out holds.
  - Both high, or both low: → NO_OP; nothing changes. Simultaneous push and pop are ignored and flag no error.
- Handshake outputs, decoded from state, each high for exactly one cycle per accepted or rejected request:
  - wr_ack = (state==WRITE); wr_err = (state==WR_ERROR).
  - rd_ack = (state==READ); rd_err = (state==RD_ERROR).
  - A request held high for N edges produces N operations/pulses.
- d_out is valid in the cycle rd_ack is high and holds until the next accepted pop or reset.
- Wrap-around: pointers roll 7→0 naturally. full/empty are derived from count, not from pointer equality.

Optional Feature:
- Macro: RF_FIFO_ALMOST_FLAGS_EN.
- Defined:
  - Adds output ports almost_full = (count >= 7) and almost_empty = (count <= 1), both combinational from count.
  - Both low during reset except almost_empty, which is 1 (count=0).
- Undefined: ports absent; all other behaviour identical.

Test Plan:
- Reset, then idle 2 cycles → empty=1, full=0, data_count=0, d_out=0, all acks/errs 0, rf_we=0.
- Push 0x11111111..0x88888888 (8 pushes) → rf_wAddr steps 0..7; wr_ack pulses 8 times; full=1, data_count=8. A 9th push → wr_err=1 for 1 cycle, rf_we=0, count stays 8.
- Pop 8 times → d_out = 0x11111111..0x88888888 in order, rd_ack each cycle; empty=1. A 9th pop → rd_err=1, d_out stays 0x88888888.
- Wrap-around:
  - Push 5, pop 5, then push 6 → tail wraps to 3 and data_count=6.
  - Popping 6 returns the pushed values in order, with rf_rAddr sequence 5,6,7,0,1,2.
- wr_en=rd_en=1 with count=3 → NO_OP: no acks/errs, count=3, rf_we=0, pointers unchanged.
- reset_n=0 for one edge mid-stream at count=4 → count=0, head=tail=0, d_out=0, state INIT. A subsequent pop → rd_err.
